// File: rtl/init_seq_pkg.sv
// Shared types and helpers for the power-up sequencer.
package init_seq_pkg;

    // Sequencer FSM states.
    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        WAIT,
        READY,
        FAIL
    } state_t;

    // Alternating LED pattern shown in FAIL; callers take the low LED_W bits.
    localparam logic [31:0] LED_FAIL_PAT = 32'hAAAA_AAAA;

    // FAIL blink period is 2^BLINK_W cycles.
    localparam int BLINK_W = 22;

    // Index of the lowest set bit of v, or 0 when v is all zeros.
    function automatic int lowest_set(input logic [31:0] v);
        int idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/init_stage_timer.sv
// Loadable down-counter shared by the HOLD and WAIT phases. It sits at zero
// once it runs out; expired is high while counting is enabled and the count
// has reached zero, so the owning state sees it on its last cycle.
module init_stage_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);

    logic [W-1:0] count;

    // Clear beats load, load beats decrement; saturate at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  count <= '0;
        else if (clear)              count <= '0;
        else if (load)               count <= load_val;
        else if (en && count != '0)  count <= count - 1'b1;
    end

    assign expired = en && (count == '0);

endmodule

// File: rtl/init_sequencer.sv
// Power-up sequencer: releases subsystem resets one at a time, waits for each
// done flag with timeout and retry, steers the shared bus pins, then
// supervises the running system.
module init_sequencer
    import init_seq_pkg::*;
#(
    parameter int                  N_STAGES       = 4,
    parameter int                  HOLD_CYCLES    = 16,
    parameter int                  TIMEOUT_CYCLES = 27_000_000,
    parameter int                  RETRY_MAX      = 2,
    parameter logic [N_STAGES-1:0] BUS_MASK       = 4'b0110,
    parameter int                  LED_W          = 6
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_STAGES-1:0]            stage_done,
    input  logic                           restart,
    output logic [N_STAGES-1:0]            stage_rst_n,
    output logic [$clog2(N_STAGES)-1:0]    bus_sel,
    output logic                           all_ready,
    output logic                           fail,
    output logic [$clog2(N_STAGES)-1:0]    fail_stage,
    output logic [$clog2(RETRY_MAX+1)-1:0] retry_cnt,
    output logic [LED_W-1:0]               led
);

    localparam int SW   = $clog2(N_STAGES);
    localparam int RW   = $clog2(RETRY_MAX + 1);
    localparam int TMAX = (TIMEOUT_CYCLES > HOLD_CYCLES) ? TIMEOUT_CYCLES : HOLD_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    // Bus owner before any stage has claimed the pins.
    localparam logic [SW-1:0] BUS_RST = SW'(lowest_set(32'(BUS_MASK)));

    state_t              state;
    logic [SW-1:0]       k;
    logic [SW-1:0]       k_next;
    logic [BLINK_W-1:0]  blink;
    logic [N_STAGES-1:0] not_done;
    logic                tmr_clr, tmr_load, tmr_en, tmr_exp;
    logic [TW-1:0]       tmr_val;

    assign k_next   = k + 1'b1;
    assign not_done = ~stage_done;
    assign tmr_en   = (state == HOLD) || (state == WAIT);

    init_stage_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (tmr_clr),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .expired  (tmr_exp)
    );

    // Timer reload: each edge that enters HOLD loads the hold length, the
    // edge leaving HOLD loads the WAIT timeout.
    always_comb begin
        tmr_clr  = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = TW'(HOLD_CYCLES - 1);
        if (restart) begin
            tmr_clr = 1'b1;
        end else begin
            case (state)
                IDLE: tmr_load = 1'b1;
                HOLD: if (tmr_exp) begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(TIMEOUT_CYCLES - 1);
                end
                WAIT: if (stage_done[k] || tmr_exp) tmr_load = 1'b1;
                default: ;
            endcase
        end
    end

    // Sequencer FSM with registered outputs; restart mirrors reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            k           <= '0;
            stage_rst_n <= '0;
            bus_sel     <= BUS_RST;
            all_ready   <= 1'b0;
            fail        <= 1'b0;
            fail_stage  <= '0;
            retry_cnt   <= '0;
            led         <= '1;
            blink       <= '0;
        end else if (restart) begin
            state       <= IDLE;
            k           <= '0;
            stage_rst_n <= '0;
            bus_sel     <= BUS_RST;
            all_ready   <= 1'b0;
            fail        <= 1'b0;
            fail_stage  <= '0;
            retry_cnt   <= '0;
            led         <= '1;
            blink       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    k     <= '0;
                    state <= HOLD;
                    if (BUS_MASK[0]) bus_sel <= '0;
                end
                HOLD: begin
                    if (tmr_exp) begin
                        stage_rst_n[k] <= 1'b1;
                        state          <= WAIT;
                    end
                end
                WAIT: begin
                    // Done wins over a timeout landing in the same cycle.
                    if (stage_done[k]) begin
                        led       <= {led[LED_W-2:0], 1'b0};
                        retry_cnt <= '0;
                        if (k == SW'(N_STAGES - 1)) begin
                            state     <= READY;
                            all_ready <= 1'b1;
                        end else begin
                            k     <= k_next;
                            state <= HOLD;
                            if (BUS_MASK[k_next]) bus_sel <= k_next;
                        end
                    end else if (tmr_exp) begin
                        if (retry_cnt < RW'(RETRY_MAX)) begin
                            retry_cnt      <= retry_cnt + 1'b1;
                            stage_rst_n[k] <= 1'b0;
                            state          <= HOLD;
                            if (BUS_MASK[k]) bus_sel <= k;
                        end else begin
                            fail_stage <= k;
                            fail       <= 1'b1;
                            led        <= LED_FAIL_PAT[LED_W-1:0];
                            blink      <= '0;
                            state      <= FAIL;
                        end
                    end
                end
                READY: begin
                    if (stage_done != '1) begin
                        fail_stage <= SW'(lowest_set(32'(not_done)));
                        all_ready  <= 1'b0;
                        fail       <= 1'b1;
                        led        <= LED_FAIL_PAT[LED_W-1:0];
                        blink      <= '0;
                        state      <= FAIL;
                    end
                end
                FAIL: begin
                    // Terminal: resets stay as they are, LEDs blink.
                    blink <= blink + 1'b1;
                    if (&blink) led <= ~led;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_init_sequencer.sv
// Directed-sequence bench with randomized done latencies and supervision
// drops; expected outputs come from simple arithmetic on stage progress.
module tb_init_sequencer;

    localparam int N     = 3;
    localparam int HOLD  = 4;
    localparam int TMO   = 100;
    localparam int RETRY = 1;
    localparam int LW    = 6;
    localparam logic [N-1:0] MASK = 3'b110;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          restart;
    logic [N-1:0]  stage_done;
    logic [N-1:0]  stage_rst_n;
    logic [1:0]    bus_sel;
    logic          all_ready;
    logic          fail;
    logic [1:0]    fail_stage;
    logic [0:0]    retry_cnt;
    logic [LW-1:0] led;

    int checks = 0;
    int errors = 0;

    init_sequencer #(
        .N_STAGES       (N),
        .HOLD_CYCLES    (HOLD),
        .TIMEOUT_CYCLES (TMO),
        .RETRY_MAX      (RETRY),
        .BUS_MASK       (MASK),
        .LED_W          (LW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stage_done  (stage_done),
        .restart     (restart),
        .stage_rst_n (stage_rst_n),
        .bus_sel     (bus_sel),
        .all_ready   (all_ready),
        .fail        (fail),
        .fail_stage  (fail_stage),
        .retry_cnt   (retry_cnt),
        .led         (led)
    );

    always #5 clk = ~clk;

    // Stages 0..n-1 released, the rest held.
    function automatic logic [31:0] exp_rst(input int n);
        return (32'd1 << n) - 32'd1;
    endfunction

    // One LED turned on (driven low) per completed stage.
    function automatic logic [31:0] exp_led(input int n);
        logic [LW-1:0] v;
        v = '1;
        v = v << n;
        return 32'(v);
    endfunction

    // Bus owner once stage k has entered HOLD: latest masked stage so far.
    function automatic logic [31:0] exp_bus(input int k);
        int b;
        b = 0;
        for (int j = N - 1; j >= 0; j--) if (MASK[j]) b = j;
        for (int j = 0; j <= k; j++) if (MASK[j]) b = j;
        return 32'(b);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, " stage_rst_n"}, 32'(stage_rst_n), 32'd0);
        check({tag, " led"},         32'(led),         32'h3F);
        check({tag, " bus_sel"},     32'(bus_sel),     32'd1);
        check({tag, " all_ready"},   32'(all_ready),   32'd0);
        check({tag, " fail"},        32'(fail),        32'd0);
        check({tag, " fail_stage"},  32'(fail_stage),  32'd0);
        check({tag, " retry_cnt"},   32'(retry_cnt),   32'd0);
    endtask

    // Entry: the edge that put stage k into HOLD has just been observed.
    // nfail attempts time out, then done rises d cycles after release
    // (unless retries run out, which must end in FAIL).
    task automatic run_stage(input int k, input int nfail, input int d);
        for (int a = 0; a <= nfail; a++) begin
            check($sformatf("s%0d bus_sel", k), 32'(bus_sel), exp_bus(k));
            repeat (HOLD - 1) tick();
            check($sformatf("s%0d held a%0d", k, a), 32'(stage_rst_n), exp_rst(k));
            tick();
            check($sformatf("s%0d released a%0d", k, a), 32'(stage_rst_n), exp_rst(k + 1));
            if (a < nfail) begin
                repeat (TMO - 1) tick();
                check($sformatf("s%0d pre-timeout", k), 32'(stage_rst_n), exp_rst(k + 1));
                tick();
                if (a < RETRY) begin
                    check($sformatf("s%0d retry rst", k), 32'(stage_rst_n), exp_rst(k));
                    check($sformatf("s%0d retry_cnt", k), 32'(retry_cnt), 32'(a + 1));
                end else begin
                    check($sformatf("s%0d exhausted fail", k), 32'(fail), 32'd1);
                    check($sformatf("s%0d fail_stage", k), 32'(fail_stage), 32'(k));
                    check($sformatf("s%0d fail rst", k), 32'(stage_rst_n), exp_rst(k + 1));
                    check($sformatf("s%0d fail all_ready", k), 32'(all_ready), 32'd0);
                    check($sformatf("s%0d fail led", k), 32'(led), 32'h2A);
                    return;
                end
            end
        end
        repeat (d - 1) tick();
        stage_done[k] = 1'b1;
        tick();
        check($sformatf("s%0d led", k), 32'(led), exp_led(k + 1));
        check($sformatf("s%0d retry clear", k), 32'(retry_cnt), 32'd0);
        check($sformatf("s%0d all_ready", k), 32'(all_ready), (k == N - 1) ? 32'd1 : 32'd0);
        check($sformatf("s%0d rst after done", k), 32'(stage_rst_n), exp_rst(k + 1));
    endtask

    // Drop the done bits in drop while READY; lowest dropped index is blamed.
    task automatic supervise(input logic [N-1:0] drop);
        int lo;
        lo = 0;
        for (int j = N - 1; j >= 0; j--) if (drop[j]) lo = j;
        check("ready before drop", 32'(all_ready), 32'd1);
        stage_done = stage_done & ~drop;
        tick();
        stage_done = '1;
        check("sup fail",       32'(fail),        32'd1);
        check("sup all_ready",  32'(all_ready),   32'd0);
        check("sup fail_stage", 32'(fail_stage),  32'(lo));
        check("sup led",        32'(led),         32'h2A);
        check("sup rst held",   32'(stage_rst_n), exp_rst(N));
        repeat (3) tick();
        check("fail terminal",  32'(fail),        32'd1);
    endtask

    task automatic do_restart(input string tag);
        restart    = 1'b1;
        stage_done = '0;
        tick();
        restart = 1'b0;
        check_reset(tag);
        tick();
    endtask

    initial begin
        logic [N-1:0] drop;
        int r;
        rst_n      = 1'b0;
        restart    = 1'b0;
        stage_done = '0;
        repeat (2) tick();
        check_reset("reset");
        rst_n = 1'b1;
        tick();

        // Happy path; first stage uses the nominal 10-cycle latency.
        run_stage(0, 0, 10);
        run_stage(1, 0, int'($urandom_range(99, 1)));
        run_stage(2, 0, int'($urandom_range(99, 1)));
        supervise(3'b001);

        // Restart from FAIL; stage 1 retries once then completes on the
        // cycle its timeout would fire.
        do_restart("restart fail");
        run_stage(0, 0, int'($urandom_range(99, 1)));
        run_stage(1, 1, TMO);
        run_stage(2, 0, int'($urandom_range(99, 1)));
        drop = N'($urandom_range(7, 1));
        supervise(drop);

        // Restart mid-WAIT of stage 1, then exhaust retries on stage 2.
        do_restart("restart fail2");
        run_stage(0, 0, int'($urandom_range(99, 1)));
        check("s1 bus mid", 32'(bus_sel), exp_bus(1));
        repeat (HOLD) tick();
        r = int'($urandom_range(50, 1));
        repeat (r) tick();
        check("mid-wait rst", 32'(stage_rst_n), exp_rst(2));
        do_restart("restart wait");
        run_stage(0, 0, int'($urandom_range(99, 1)));
        run_stage(1, 0, int'($urandom_range(99, 1)));
        run_stage(2, 2, 1);

        // Async reset during HOLD of stage 1 acts without a clock edge.
        do_restart("restart fail3");
        run_stage(0, 0, int'($urandom_range(99, 1)));
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("async");
        stage_done = '0;
        #1;
        rst_n = 1'b1;
        tick();
        run_stage(0, 0, int'($urandom_range(99, 1)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
